fwrisc_dmem_target: RTL and testbench

Data-memory responder for the FWRISC data bus. It sits at the far end of the core's `dvalid`/`daddr`/`dwrite`/`dwdata`/`dwstb` → `drdata`/`dready` interface. It decodes each request against its address window and stores writes into an internal word-wide RAM with byte-lane strobes. Each transfer completes with a one-cycle `dready` pulse after a configurable number of wait states.

---
 rtl/fwrisc_dmem_target_if.sv | 21 ++
 rtl/fwrisc_dmem_target.sv | 130 +++++++++++++
 tb/tb_fwrisc_dmem_target.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_dmem_target_if.sv
// FWRISC data-bus interface: core request fields and responder completion fields.
interface fwrisc_dmem_target_if;
  logic        dvalid;
  logic [31:0] daddr;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic [31:0] drdata;
  logic        dready;
  logic        derr;

  modport master (
    output dvalid, daddr, dwrite, dwdata, dwstb,
    input  drdata, dready, derr
  );

  modport slave (
    input  dvalid, daddr, dwrite, dwdata, dwstb,
    output drdata, dready, derr
  );
endinterface

// File: rtl/fwrisc_dmem_target.sv
// Data-memory responder for the FWRISC data bus: windowed word RAM with byte strobes.
// Define FWRISC_DMEM_WAIT_EN to compile in WAIT_STATES wait cycles before dready.
module fwrisc_dmem_target #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                 clock,
  input logic                 reset,
  fwrisc_dmem_target_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned TAG_LSB = ADDR_BITS + 2;
`ifdef FWRISC_DMEM_WAIT_EN
  localparam int unsigned W_EFF = WAIT_STATES;
`else
  // WAIT_STATES has no effect when the wait path is compiled out
  localparam int unsigned W_EFF = WAIT_STATES * 0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [31:0] drdata_q;
  logic        dready_q;
  logic        derr_q;

  logic                 req_hit_c;
  logic [ADDR_BITS-1:0] req_idx_c;
  logic                 unused_c;

  assign req_hit_c = (bus.daddr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req_idx_c = bus.daddr[TAG_LSB-1:2];
  assign unused_c  = ^bus.daddr[1:0];

`ifdef FWRISC_DMEM_WAIT_EN
  logic [3:0]           cnt_q;
  logic                 hit_q;
  logic                 write_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          wdata_q;
  logic [3:0]           stb_q;
`endif

  // Access strobe and the fields it uses: live request from IDLE, latched copy from WAIT
  logic                 acc_c;
  logic                 acc_hit_c;
  logic                 acc_write_c;
  logic [ADDR_BITS-1:0] acc_idx_c;
  logic [31:0]          acc_wdata_c;
  logic [3:0]           acc_stb_c;

  always_comb begin
    acc_c       = (state == IDLE) && bus.dvalid && (W_EFF == 0);
    acc_hit_c   = req_hit_c;
    acc_write_c = bus.dwrite;
    acc_idx_c   = req_idx_c;
    acc_wdata_c = bus.dwdata;
    acc_stb_c   = bus.dwstb;
`ifdef FWRISC_DMEM_WAIT_EN
    if (state == WAIT) begin
      acc_c       = (cnt_q == 4'd1);
      acc_hit_c   = hit_q;
      acc_write_c = write_q;
      acc_idx_c   = idx_q;
      acc_wdata_c = wdata_q;
      acc_stb_c   = stb_q;
    end
`endif
  end

  // RAM write port; reset suppresses any commit on the same edge
  always_ff @(posedge clock) begin
    if (!reset && acc_c && acc_hit_c && acc_write_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_stb_c[i]) mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
      end
    end
  end

  // Request sequencing and registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      dready_q <= 1'b0;
      derr_q   <= 1'b0;
      drdata_q <= '0;
`ifdef FWRISC_DMEM_WAIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      dready_q <= 1'b0;
      derr_q   <= 1'b0;
      drdata_q <= '0;
      if (acc_c) begin
        state    <= RESP;
        dready_q <= 1'b1;
        derr_q   <= !acc_hit_c;
        if (acc_hit_c && !acc_write_c) drdata_q <= mem[acc_idx_c];
      end
      case (state)
        IDLE: begin
`ifdef FWRISC_DMEM_WAIT_EN
          if (bus.dvalid) begin
            hit_q   <= req_hit_c;
            write_q <= bus.dwrite;
            idx_q   <= req_idx_c;
            wdata_q <= bus.dwdata;
            stb_q   <= bus.dwstb;
            cnt_q   <= 4'(W_EFF);
            if (!acc_c) state <= WAIT;
          end
`endif
        end
`ifdef FWRISC_DMEM_WAIT_EN
        WAIT:    cnt_q <= cnt_q - 4'd1;
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.drdata = drdata_q;
  assign bus.dready = dready_q;
  assign bus.derr   = derr_q;

endmodule

// File: tb/tb_fwrisc_dmem_target.sv
// Self-checking bench for fwrisc_dmem_target against a byte-level memory model.
module tb_fwrisc_dmem_target;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam logic [31:0] BASE      = 32'h8000_0000;
`ifdef FWRISC_DMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fwrisc_dmem_target_if bus();

  fwrisc_dmem_target #(
    .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE), .WAIT_STATES(2)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  logic [31:0] model [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_win(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
  endfunction

  // Drives one request and waits (bounded) for its dready pulse
  task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                      input bit scramble, output logic [31:0] rd, output bit er, output int lat,
                      output bit ok);
    @(negedge clock);
    bus.dvalid = 1'b1; bus.daddr = a; bus.dwrite = w; bus.dwdata = d; bus.dwstb = s;
    ok = 1'b0; lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      if (bus.dready === 1'b1) begin
        rd = bus.drdata; er = bus.derr; lat = c; ok = 1'b1;
        break;
      end
      if (scramble) begin
        bus.daddr = $urandom; bus.dwrite = 1'($urandom); bus.dwdata = $urandom; bus.dwstb = 4'($urandom);
      end
    end
    bus.dvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.dready, bus.derr, bus.drdata} !== 34'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d: got rdy=%b err=%b rd=%h expected 0/0/0", c, bus.dready, bus.derr, bus.drdata);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; bit er, ok; int lat;
    xfer(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    n_cmp++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0} || lat != 1 + W) begin
      n_bad++;
      $display("FAIL wr_deadbeef: got ok=%b err=%b rd=%h lat=%0d expected 1/0/0 lat=%0d", ok, er, rd, lat, 1 + W);
    end
    xfer(32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    n_cmp++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BEEF} || lat != 1 + W) begin
      n_bad++;
      $display("FAIL rd_deadbeef: got ok=%b err=%b rd=%h lat=%0d expected 1/0/deadbeef lat=%0d", ok, er, rd, lat, 1 + W);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; bit er, ok; int lat;
    logic [31:0] a = 32'h8000_0020;
    logic [31:0] wd [4] = '{32'h1122_3344, 32'h0000_00AA, 32'h5566_0000, 32'hFFFF_FFFF};
    logic [3:0]  ws [4] = '{4'hF, 4'b0001, 4'b1100, 4'b0000};
    logic [31:0] ex [4] = '{32'h1122_3344, 32'h1122_33AA, 32'h5566_33AA, 32'h5566_33AA};
    for (int i = 0; i < 4; i++) begin
      xfer(a, 1'b1, wd[i], ws[i], 1'b0, rd, er, lat, ok);
      model_write(a, wd[i], ws[i]);
      xfer(a, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      n_cmp++;
      if ({ok, er, rd} !== {1'b1, 1'b0, ex[i]}) begin
        n_bad++;
        $display("FAIL strobe_step%0d: got ok=%b err=%b rd=%h expected 1/0/%h", i, ok, er, rd, ex[i]);
      end
    end
  endtask

  task automatic test_miss();
    logic [31:0] rd; bit er, ok; int lat;
    logic [31:0] miss_a [3] = '{32'h0000_0040, 32'h7FFF_FFFC, 32'h8000_1000};
    xfer(32'h8000_0040, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF);
    xfer(32'h8000_0FFC, 1'b1, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF);
    for (int i = 0; i < 3; i++) begin
      xfer(miss_a[i], 1'b0, 32'h0, 4'hF, 1'b0, rd, er, lat, ok);
      n_cmp++;
      if ({ok, er, rd} !== {1'b1, 1'b1, 32'h0} || lat != 1 + W) begin
        n_bad++;
        $display("FAIL miss_rd %h: got ok=%b err=%b rd=%h lat=%0d expected 1/1/0 lat=%0d", miss_a[i], ok, er, rd, lat, 1 + W);
      end
      xfer(miss_a[i], 1'b1, 32'h0BAD_BEEF, 4'hF, 1'b0, rd, er, lat, ok);
      n_cmp++;
      if ({ok, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
        n_bad++;
        $display("FAIL miss_wr %h: got ok=%b err=%b rd=%h expected 1/1/0", miss_a[i], ok, er, rd);
      end
    end
    xfer(32'h8000_0040, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    n_cmp++;
    if ({ok, er, rd} !== {1'b1, 1'b0, model[16]}) begin
      n_bad++;
      $display("FAIL miss_alias_word: got ok=%b err=%b rd=%h expected 1/0/%h", ok, er, rd, model[16]);
    end
    xfer(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    n_cmp++;
    if ({ok, er, rd} !== {1'b1, 1'b0, model[DEPTH-1]}) begin
      n_bad++;
      $display("FAIL last_word: got ok=%b err=%b rd=%h expected 1/0/%h", ok, er, rd, model[DEPTH-1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit er, ok; int lat;
    int seen;
    int cyc [2];
    logic [31:0] dat [2];
    xfer(BASE, 1'b1, 32'h0102_0304, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(BASE, 32'h0102_0304, 4'hF);
    xfer(BASE + 32'd4, 1'b1, 32'hF0E0_D0C0, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(BASE + 32'd4, 32'hF0E0_D0C0, 4'hF);
    seen = 0; cyc = '{0, 0}; dat = '{32'h0, 32'h0};
    @(negedge clock);
    bus.dvalid = 1'b1; bus.dwrite = 1'b0; bus.daddr = BASE; bus.dwstb = 4'hF; bus.dwdata = '0;
    for (int c = 1; c <= 5 + 2 * W; c++) begin
      @(negedge clock);
      if (bus.dready === 1'b1) begin
        if (seen < 2) begin cyc[seen] = c; dat[seen] = bus.drdata; end
        seen++;
        if (seen == 1) bus.daddr = BASE + 32'd4;
        else           bus.dvalid = 1'b0;
      end
    end
    bus.dvalid = 1'b0;
    n_cmp++;
    if (seen != 2 || cyc[0] != 1 + W || cyc[1] != 3 + 2 * W) begin
      n_bad++;
      $display("FAIL b2b_timing: got pulses=%0d at %0d,%0d expected 2 at %0d,%0d", seen, cyc[0], cyc[1], 1 + W, 3 + 2 * W);
    end
    n_cmp++;
    if (dat[0] !== model[0] || dat[1] !== model[1]) begin
      n_bad++;
      $display("FAIL b2b_data: got %h,%h expected %h,%h", dat[0], dat[1], model[0], model[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit er, ok; int lat;
    bit rdy_seen;
    xfer(32'h8000_0030, 1'b1, 32'h0F0F_0F0F, 4'hF, 1'b0, rd, er, lat, ok);
    model_write(32'h8000_0030, 32'h0F0F_0F0F, 4'hF);
    rdy_seen = 1'b0;
    @(negedge clock);
    bus.dvalid = 1'b1; bus.dwrite = 1'b1; bus.daddr = 32'h8000_0030; bus.dwdata = 32'h1234_5678; bus.dwstb = 4'hF;
    if (W > 0) begin
      @(negedge clock);
      rdy_seen |= (bus.dready === 1'b1);
    end
    reset = 1'b1; bus.dvalid = 1'b0;
    @(negedge clock);
    rdy_seen |= (bus.dready === 1'b1);
    reset = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clock);
      rdy_seen |= (bus.dready === 1'b1);
    end
    n_cmp++;
    if (rdy_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_ready: got dready seen=%b expected 0", rdy_seen);
    end
    xfer(32'h8000_0030, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    n_cmp++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0F0F_0F0F}) begin
      n_bad++;
      $display("FAIL reset_mid_data: got ok=%b err=%b rd=%h expected 1/0/0f0f0f0f", ok, er, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, ex; bit er, ok, w, exer; int lat;
    logic [3:0] s;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      xfer(BASE + 32'(i * 4), 1'b1, d, 4'hF, 1'b0, rd, er, lat, ok);
      model_write(BASE + 32'(i * 4), d, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 85) a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      else                             a = $urandom & 32'h7FFF_FFFF;
      w = 1'($urandom); d = $urandom; s = 4'($urandom);
      xfer(a, w, d, s, 1'($urandom), rd, er, lat, ok);
      exer = !in_win(a);
      ex   = (!w && in_win(a)) ? model[widx(a)] : 32'h0;
      if (w) model_write(a, d, s);
      n_cmp++;
      if ({ok, er, rd} !== {1'b1, exer, ex} || lat != 1 + W) begin
        n_bad++;
        $display("FAIL rand%0d a=%h w=%b: got ok=%b err=%b rd=%h lat=%0d expected 1/%b/%h lat=%0d",
                 n, a, w, ok, er, rd, lat, exer, ex, 1 + W);
      end
    end
  endtask

  initial begin
    bus.dvalid = 1'b0; bus.daddr = '0; bus.dwrite = 1'b0; bus.dwdata = '0; bus.dwstb = '0;
    test_reset();
    test_write_read();
    test_strobes();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
